// File: rtl/parity_pkg.sv
// Shared types and helpers for the framed multi-lane parity checker.
package parity_pkg;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Counter width with a floor of one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/parity_frame_check_if.sv
// Receive-side bundle of the parity checker: serial lanes in, check results out.
interface parity_frame_check_if #(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned ERR_W    = 8
);
    logic                i_clear;
    logic                i_in_valid;
    logic [CHANNELS-1:0] i_seq_in;
    logic [CHANNELS-1:0] o_det_out;
    logic                o_check_valid;
    logic [CHANNELS-1:0] o_check_ok;
    logic [ERR_W-1:0]    o_err_cnt;

    modport master (
        output i_clear, i_in_valid, i_seq_in,
        input  o_det_out, o_check_valid, o_check_ok, o_err_cnt
    );

    modport slave (
        input  i_clear, i_in_valid, i_seq_in,
        output o_det_out, o_check_valid, o_check_ok, o_err_cnt
    );
endinterface

// File: rtl/parity_lane.sv
// One lane: running parity (stored inverted as detOut) and the parity-bit compare.
module parity_lane #(
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_accept,
    input  logic i_is_parity,
    input  logic i_clear,
    input  logic i_seq,
    output logic o_det,
    output logic o_ok,
    output logic o_fail_c
);
    logic r_det;
    logic r_ok;
    logic w_ok;

    // r_det is the complement of the accumulator, so the accumulator itself is ~r_det.
    assign w_ok     = ((~r_det ^ i_seq) == 1'(ODD_PARITY));
    assign o_fail_c = ~w_ok;
    assign o_det    = r_det;
    assign o_ok     = r_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_det <= 1'b1;
        end else if (i_clear) begin
            r_det <= 1'b1;
        end else if (i_accept) begin
            r_det <= i_is_parity ? 1'b1 : (r_det ^ i_seq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ok <= 1'b0;
        end else if (i_accept && i_is_parity) begin
            r_ok <= w_ok;
        end
    end
endmodule

// File: rtl/parity_frame_check.sv
// Framed multi-lane parity checker: shared Data/Parity FSM, bit counter and saturating error count.
module parity_frame_check
    import parity_pkg::*;
#(
    parameter int unsigned WORD_LEN   = 8,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned ERR_W      = 8
) (
    input logic                  clk,
    input logic                  rst,
    parity_frame_check_if.slave  bus
);
    localparam int unsigned CNT_W   = cnt_width(WORD_LEN);
    localparam int unsigned POP_W   = cnt_width(CHANNELS + 1);
    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_check_valid;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                w_accept;
    logic                w_is_parity;
    logic                w_last_bit;
    logic [CHANNELS-1:0] w_det;
    logic [CHANNELS-1:0] w_ok;
    logic [CHANNELS-1:0] w_fail;
    logic [POP_W-1:0]    w_fail_cnt;

    // clear wins over a simultaneous valid bit, which is dropped.
    assign w_accept    = bus.i_in_valid & ~bus.i_clear;
    assign w_is_parity = (r_state == ST_PARITY);
    assign w_last_bit  = (r_bit_cnt == CNT_W'(WORD_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_clear) begin
            w_state_nxt = ST_DATA;
        end else if (bus.i_in_valid) begin
            case (r_state)
                ST_DATA:   if (w_last_bit) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_DATA;
                default:   w_state_nxt = ST_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
        end else if (bus.i_clear) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= w_is_parity ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_lane
        parity_lane #(
            .ODD_PARITY (ODD_PARITY)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_accept    (w_accept),
            .i_is_parity (w_is_parity),
            .i_clear     (bus.i_clear),
            .i_seq       (bus.i_seq_in[g]),
            .o_det       (w_det[g]),
            .o_ok        (w_ok[g]),
            .o_fail_c    (w_fail[g])
        );
    end

    // Number of lanes failing the current parity bit.
    always_comb begin
        w_fail_cnt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_fail_cnt = w_fail_cnt + POP_W'(w_fail[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_check_valid <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_check_valid <= w_accept & w_is_parity;
            if (bus.i_clear) begin
                r_err_cnt <= '0;
            end else if (w_accept && w_is_parity) begin
                r_err_cnt <= ERR_W'(sat_add(32'(r_err_cnt), 32'(w_fail_cnt), ERR_MAX));
            end
        end
    end

    assign bus.o_det_out     = w_det;
    assign bus.o_check_valid = r_check_valid;
    assign bus.o_check_ok    = w_ok;
    assign bus.o_err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_parity_frame_check.sv
// Three checker configurations on one shared stimulus stream, compared each cycle against a bit-counting model.
module tb_parity_frame_check;
    localparam int NDUT = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       clear = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] seq   = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // A: WL=8 CH=4 even ERR_W=8;  B: WL=8 CH=1 odd ERR_W=2;  C: WL=1 CH=2 even ERR_W=3
    parity_frame_check_if #(.CHANNELS(4), .ERR_W(8)) if_a ();
    parity_frame_check_if #(.CHANNELS(1), .ERR_W(2)) if_b ();
    parity_frame_check_if #(.CHANNELS(2), .ERR_W(3)) if_c ();

    assign if_a.i_clear = clear;  assign if_a.i_in_valid = valid;  assign if_a.i_seq_in = seq;
    assign if_b.i_clear = clear;  assign if_b.i_in_valid = valid;  assign if_b.i_seq_in = seq[0];
    assign if_c.i_clear = clear;  assign if_c.i_in_valid = valid;  assign if_c.i_seq_in = seq[1:0];

    parity_frame_check #(.WORD_LEN(8), .CHANNELS(4), .ODD_PARITY(0), .ERR_W(8))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    parity_frame_check #(.WORD_LEN(8), .CHANNELS(1), .ODD_PARITY(1), .ERR_W(2))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    parity_frame_check #(.WORD_LEN(1), .CHANNELS(2), .ODD_PARITY(0), .ERR_W(3))
        u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [3:0] act_det [NDUT];
    logic       act_cv  [NDUT];
    logic [3:0] act_ok  [NDUT];
    logic [7:0] act_err [NDUT];

    assign act_det[0] = if_a.o_det_out;          assign act_det[1] = {3'b0, if_b.o_det_out};
    assign act_det[2] = {2'b0, if_c.o_det_out};
    assign act_cv[0]  = if_a.o_check_valid;      assign act_cv[1]  = if_b.o_check_valid;
    assign act_cv[2]  = if_c.o_check_valid;
    assign act_ok[0]  = if_a.o_check_ok;         assign act_ok[1]  = {3'b0, if_b.o_check_ok};
    assign act_ok[2]  = {2'b0, if_c.o_check_ok};
    assign act_err[0] = if_a.o_err_cnt;          assign act_err[1] = {6'b0, if_b.o_err_cnt};
    assign act_err[2] = {5'b0, if_c.o_err_cnt};

    function automatic int cfg_wl(input int d);  return (d == 2) ? 1 : 8; endfunction
    function automatic int cfg_ch(input int d);  return (d == 0) ? 4 : (d == 1) ? 1 : 2; endfunction
    function automatic int cfg_odd(input int d); return (d == 1) ? 1 : 0; endfunction
    function automatic int cfg_max(input int d); return (d == 0) ? 255 : (d == 1) ? 3 : 7; endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Behavioural model: count data ones per lane, judge the word when the parity bit arrives.
    int         m_cnt  [NDUT];
    int         m_ones [NDUT][4];
    logic [3:0] e_det  [NDUT];
    logic       e_cv   [NDUT];
    logic [3:0] e_ok   [NDUT];
    int         e_err  [NDUT];

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst) begin
                    m_cnt[d] = 0;
                    for (int l = 0; l < 4; l++) m_ones[d][l] = 0;
                    e_cv[d]  = 1'b0;
                    e_ok[d]  = 4'h0;
                    e_err[d] = 0;
                end else begin
                    e_cv[d] = 1'b0;
                    if (clear) begin
                        m_cnt[d] = 0;
                        for (int l = 0; l < 4; l++) m_ones[d][l] = 0;
                        e_err[d] = 0;
                    end else if (valid) begin
                        if (m_cnt[d] == cfg_wl(d)) begin
                            int fails;
                            fails = 0;
                            for (int l = 0; l < cfg_ch(d); l++) begin
                                e_ok[d][l] = (((m_ones[d][l] + int'(seq[l])) % 2) == cfg_odd(d));
                                if (!e_ok[d][l]) fails++;
                                m_ones[d][l] = 0;
                            end
                            m_cnt[d] = 0;
                            e_cv[d]  = 1'b1;
                            e_err[d] = (e_err[d] + fails > cfg_max(d)) ? cfg_max(d) : e_err[d] + fails;
                        end else begin
                            for (int l = 0; l < cfg_ch(d); l++) m_ones[d][l] += int'(seq[l]);
                            m_cnt[d]++;
                        end
                    end
                end
                e_det[d] = 4'h0;
                for (int l = 0; l < cfg_ch(d); l++) e_det[d][l] = ((m_ones[d][l] % 2) == 0);
            end
        end
    end

    int cyc     = 0;
    int last_cv = 0;
    int cv_gap  = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < NDUT; d++) begin
                chk("det_out",     d, 32'(act_det[d]), 32'(e_det[d]));
                chk("check_valid", d, 32'(act_cv[d]),  32'(e_cv[d]));
                chk("check_ok",    d, 32'(act_ok[d]),  32'(e_ok[d]));
                chk("err_cnt",     d, 32'(act_err[d]), 32'(e_err[d]));
            end
            if (act_cv[0]) begin
                if (last_cv != 0) cv_gap = cyc - last_cv;
                last_cv = cyc;
            end
        end
    end

    task automatic send(input logic v, input logic [3:0] s, input logic c);
        valid = v;
        seq   = s;
        clear = c;
        @(negedge clk);
    endtask

    task automatic word(input logic [7:0] dat, input logic [3:0] par);
        for (int i = 7; i >= 0; i--) send(1'b1, {4{dat[i]}}, 1'b0);
        send(1'b1, par, 1'b0);
    endtask

    logic [7:0] det_pat;
    logic [7:0] w1_dat;
    int         sat_exp [5];

    initial begin
        det_pat = 8'b1100_0100;
        w1_dat  = 8'b1011_0010;
        sat_exp = '{1, 2, 3, 3, 3};

        repeat (3) @(negedge clk);
        chk("reset det", 0, 32'(if_a.o_det_out), 32'hF);
        chk("reset cv",  0, 32'(if_a.o_check_valid), 32'h0);
        chk("reset ok",  0, 32'(if_a.o_check_ok), 32'h0);
        chk("reset err", 0, 32'(if_a.o_err_cnt), 32'h0);
        #1 rst = 1'b1;

        // word 1: running parity toggles per one, parity bit 0
        for (int k = 0; k < 8; k++) begin
            send(1'b1, {4{w1_dat[7-k]}}, 1'b0);
            chk("w1 det lane0", 0, 32'(if_a.o_det_out[0]), 32'(det_pat[k]));
        end
        send(1'b1, 4'h0, 1'b0);
        chk("w1 cv",  0, 32'(if_a.o_check_valid), 32'h1);
        chk("w1 ok",  0, 32'(if_a.o_check_ok), 32'hF);
        chk("w1 err", 0, 32'(if_a.o_err_cnt), 32'h0);
        chk("w1 ok",  1, 32'(if_b.o_check_ok), 32'h0);
        chk("w1 err", 1, 32'(if_b.o_err_cnt), 32'h1);

        word(w1_dat, 4'hF);
        chk("w2 ok",  0, 32'(if_a.o_check_ok), 32'h0);
        chk("w2 err", 0, 32'(if_a.o_err_cnt), 32'h4);
        chk("w2 ok",  1, 32'(if_b.o_check_ok), 32'h1);

        word(8'h00, 4'b0100);
        chk("w3 ok",  0, 32'(if_a.o_check_ok), 32'b1011);
        chk("w3 err", 0, 32'(if_a.o_err_cnt), 32'h5);
        word(8'h00, 4'b1001);
        chk("w4 ok",  0, 32'(if_a.o_check_ok), 32'b0110);
        chk("w4 err", 0, 32'(if_a.o_err_cnt), 32'h7);
        send(1'b0, 4'h0, 1'b0);
        chk("cv spacing", 0, 32'(cv_gap), 32'd9);

        send(1'b0, 4'h0, 1'b1);
        chk("clear err", 0, 32'(if_a.o_err_cnt), 32'h0);

        // saturation on the 2-bit counter
        for (int n = 0; n < 5; n++) begin
            word(8'h00, 4'h0);
            chk("sat err", 1, 32'(if_b.o_err_cnt), 32'(sat_exp[n]));
            chk("sat ok",  0, 32'(if_a.o_check_ok), 32'hF);
        end

        // clear together with data bit 4
        for (int k = 0; k < 4; k++) send(1'b1, 4'hF, 1'b0);
        send(1'b1, 4'hF, 1'b1);
        chk("clr det", 0, 32'(if_a.o_det_out), 32'hF);
        chk("clr cv",  0, 32'(if_a.o_check_valid), 32'h0);
        chk("clr err", 1, 32'(if_b.o_err_cnt), 32'h0);
        word(8'hA5, 4'h0);
        chk("post clr ok",  0, 32'(if_a.o_check_ok), 32'hF);
        chk("post clr err", 1, 32'(if_b.o_err_cnt), 32'h1);

        // reset on data bit 6
        for (int k = 0; k < 6; k++) send(1'b1, 4'h5, 1'b0);
        valid = 1'b1;
        seq   = 4'hF;
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        chk("rst det", 0, 32'(if_a.o_det_out), 32'hF);
        chk("rst cv",  0, 32'(if_a.o_check_valid), 32'h0);
        chk("rst err", 1, 32'(if_b.o_err_cnt), 32'h0);
        word(8'hA5, 4'hF);
        chk("post rst ok",  0, 32'(if_a.o_check_ok), 32'h0);
        chk("post rst err", 0, 32'(if_a.o_err_cnt), 32'h4);
        chk("post rst ok",  1, 32'(if_b.o_check_ok), 32'h1);

        // random bits with 0..3 cycle gaps
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) send(1'b0, 4'($urandom), 1'b0);
            send(1'b1, 4'($urandom), 1'b0);
        end
        // random continuous stream with occasional clears
        for (int n = 0; n < 400; n++) begin
            send(1'($urandom_range(0, 7) != 0), 4'($urandom), 1'($urandom_range(0, 49) == 0));
        end
        send(1'b0, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_frame_check.md
# parity_frame_check

Multi-lane, framed serial parity checker: the next generation of the single-bit running-parity FSM. Each of CHANNELS lanes receives WORD_LEN data bits followed by one parity bit, all lanes sharing one valid strobe and bit counter. Reports the running parity per lane, a one-cycle per-word check result, and a saturating error count. Sits directly behind serial receivers, ahead of word assembly and error logging.

## Interface
- WORD_LEN, 8: data bits per word, excluding the parity bit; legal range 1..256.
- CHANNELS, 1: number of independent serial lanes.
- ODD_PARITY, 0: 0 means data bits plus parity bit must XOR to 0 (even); 1 means they must XOR to 1 (odd).
- ERR_W, 8: width of the error counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart: drops the partial word and zeroes errCnt.
- inValid  in  1  qualifies seqIn this cycle; one bit per lane is accepted when high.
- seqIn  in  CHANNELS  serial data, bit i belongs to lane i.
- detOut  out  CHANNELS  running parity flag per lane: 1 while the accepted data bits of the current word hold an even number of ones.
- checkValid  out  1  single-cycle pulse: a word's parity bit has been checked.
- checkOk  out  CHANNELS  per-lane result; meaningful only while checkValid=1.
- errCnt  out  ERR_W  saturating count of failed lane checks since reset or clear.

## Operation
- FSM states, shared across lanes: Data and Parity. Reset state is Data.
- Data: each inValid=1 cycle XORs seqIn[i] into lane i's accumulator and increments bitCnt, of width clog2(WORD_LEN) with a minimum of 1. The FSM moves to Parity when the accepted bit is number WORD_LEN-1. When WORD_LEN=1, the first valid bit moves the FSM straight to Parity.
- Parity: the inValid=1 bit is the parity bit. For each lane, ok[i] = ((acc[i] XOR seqIn[i]) == ODD_PARITY). In the same edge, the accumulators return to 0, bitCnt returns to 0, and the FSM returns to Data.
- inValid=0 in either state: the cycle is a hold and no state changes.
- detOut[i] = NOT acc[i], registered and Moore-style. After a parity bit is accepted it reads 1 again.
- errCnt adds the number of lanes with ok[i]=0 on each check. The sum saturates at 2^ERR_W-1 and never wraps.
- clear=1: in the next state, FSM=Data, bitCnt=0, all accumulators=0 and errCnt=0. checkValid is 0 in the following cycle. clear has priority over a simultaneous inValid, and that bit is discarded.
- Reset asserted mid-word: all state returns to reset values immediately and the partial word is lost.

## Timing
- Reset values: detOut all ones, checkValid=0, checkOk all zeros, errCnt=0, FSM=Data, bitCnt=0.
- Latency: checkValid and checkOk are registered and appear in the cycle after the parity bit is sampled. errCnt updates on the same edge, so it is visible alongside checkValid.
- checkOk holds its last value between pulses. Consumers sample it only while checkValid=1.
- detOut reflects all bits accepted up to and including the previous edge.
- Back-to-back words with inValid held high are supported at full rate: one word every WORD_LEN+1 cycles with no bubble. A checkValid pulse can therefore coincide with the first data bit of the next word.
- There is no backpressure. The block always accepts.

## Structure
- Shared package parity_pkg holds:
  - the FSM state enum (Data, Parity);
  - a clog2 helper;
  - the saturating-add helper used for errCnt.
- Sub-module parity_lane, instantiated CHANNELS times, holds the accumulator register, detOut and the checkOk compare. It takes the shared accept, isParity and clear controls.
- The top level holds the FSM, bitCnt, checkValid and the errCnt popcount and saturation logic.

## Test plan
- Reset, then WORD_LEN=8, CHANNELS=1, even parity: feed data 0b1011_0010 then parity bit 0 -> detOut toggles per one seen; checkValid pulses once, checkOk=1, errCnt=0.
- Same data with parity bit 1 -> checkOk=0, errCnt=1. With ODD_PARITY=1, the same stimulus gives checkOk=1.
- CHANNELS=4: lane 2 corrupted in one word and lanes 0 and 3 corrupted in the next, continuous inValid -> checkValid pulses 9 cycles apart, checkOk=1011 then 0110, errCnt goes 1 then 3.
- inValid gaps of random 0 to 3 cycles inside a word -> results identical to the gap-free run. detOut and bitCnt hold during gaps.
- ERR_W=2, five consecutive bad words -> errCnt reads 1, 2, 3, 3, 3.
- clear asserted together with inValid on data bit 4, and separately rst pulsed low on data bit 6 -> partial word discarded, no checkValid, detOut all ones, errCnt=0. The next full word checks correctly.
